// File: rtl/i2c_master_tx_sequencer.sv
// rtl/i2c_master_tx_sequencer.sv - I2C master write sequencer driving a bit-level write stage and ack stage
// Optional macro I2C_NACK_ABORT_EN: a NACK jumps straight to STOP instead of continuing the transfer.
module i2c_master_tx_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_req,
    input  logic [6:0] slave_addr,
    input  logic [3:0] byte_count,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    output logic       wr_go,
    output logic [2:0] wr_command,
    output logic       wr_data,
    input  logic       wr_load,
    input  logic       wr_finish,
    output logic       ack_go,
    input  logic       ack_finish,
    input  logic       ack_bit
);

`ifdef I2C_NACK_ABORT_EN
    localparam bit NACK_ABORT = 1'b1;
`else
    localparam bit NACK_ABORT = 1'b0;
`endif

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_START = 3'b001;
    localparam logic [2:0] CMD_DATA  = 3'b011;
    localparam logic [2:0] CMD_STOP  = 3'b100;

    typedef enum logic [2:0] {
        IDLE, START, ADDR, ADDR_ACK, FETCH, DATA, DATA_ACK, STOP
    } state_t;

    state_t     state, next_state;
    logic       releasing, next_releasing;
    logic [7:0] shreg;
    logic [3:0] remaining;
    logic       done_q, nack_q;

    logic accept_start, load_byte, shift_en, ack_sample, stop_end;

    assign wr_data  = shreg[7];
    assign done     = done_q;
    assign nack_err = nack_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            releasing <= 1'b0;
        end else begin
            state     <= next_state;
            releasing <= next_releasing;
        end
    end

    always_comb begin
        next_state     = state;
        next_releasing = releasing;
        busy           = (state != IDLE);
        tx_ready       = 1'b0;
        wr_go          = 1'b0;
        wr_command     = CMD_IDLE;
        ack_go         = 1'b0;
        accept_start   = 1'b0;
        load_byte      = 1'b0;
        shift_en       = 1'b0;
        ack_sample     = 1'b0;
        stop_end       = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    accept_start = 1'b1;
                    next_state   = START;
                end
            end
            START, ADDR, DATA, STOP: begin
                // Each command: ISSUE until wr_finish rises, then RELEASE until it falls.
                wr_go    = !releasing;
                shift_en = (state == ADDR) || (state == DATA);
                case (state)
                    START:   wr_command = CMD_START;
                    STOP:    wr_command = CMD_STOP;
                    default: wr_command = CMD_DATA;
                endcase
                if (!releasing) begin
                    if (wr_finish) next_releasing = 1'b1;
                end else if (!wr_finish) begin
                    next_releasing = 1'b0;
                    case (state)
                        START: next_state = ADDR;
                        ADDR:  next_state = ADDR_ACK;
                        DATA:  next_state = DATA_ACK;
                        default: begin
                            next_state = IDLE;
                            stop_end   = 1'b1;
                        end
                    endcase
                end
            end
            ADDR_ACK, DATA_ACK: begin
                ack_go = 1'b1;
                if (ack_finish) begin
                    ack_sample = 1'b1;
                    if ((ack_bit && NACK_ABORT) || (remaining == 4'd0))
                        next_state = STOP;
                    else
                        next_state = FETCH;
                end
            end
            FETCH: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    load_byte  = 1'b1;
                    next_state = DATA;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg     <= 8'd0;
            remaining <= 4'd0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            done_q <= stop_end;
            if (accept_start) begin
                shreg     <= {slave_addr, 1'b0};
                remaining <= byte_count;
                nack_q    <= 1'b0;
            end else if (load_byte) begin
                shreg     <= tx_data;
                remaining <= remaining - 4'd1;
            end else if (shift_en && wr_load) begin
                shreg <= {shreg[6:0], 1'b0};
            end
            if (ack_sample && ack_bit)
                nack_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_master_tx_sequencer.sv
// tb/tb_i2c_master_tx_sequencer.sv - directed self-checking bench for i2c_master_tx_sequencer
module tb_i2c_master_tx_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_req;
    logic [6:0] slave_addr;
    logic [3:0] byte_count;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       nack_err;
    logic       wr_go;
    logic [2:0] wr_command;
    logic       wr_data;
    logic       wr_load;
    logic       wr_finish;
    logic       ack_go;
    logic       ack_finish;
    logic       ack_bit;

    i2c_master_tx_sequencer dut (
        .clock(clock), .reset(reset), .start_req(start_req),
        .slave_addr(slave_addr), .byte_count(byte_count),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .nack_err(nack_err),
        .wr_go(wr_go), .wr_command(wr_command), .wr_data(wr_data),
        .wr_load(wr_load), .wr_finish(wr_finish),
        .ack_go(ack_go), .ack_finish(ack_finish), .ack_bit(ack_bit)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] cmd_vec;
    int          cmd_n;
    logic [63:0] byte_vec;
    int          byte_n;
    int          done_cnt;
    int          rdy_cnt;
    int          ack_n;
    int          nack_at;
    int          stall_cycles;
    int          stall_bad;
    logic [7:0]  tx_q[$];

    task automatic step();
        @(negedge clock);
        if (done === 1'b1) done_cnt++;
        if (tx_ready === 1'b1) rdy_cnt++;
    endtask

    task automatic serve_write();
        logic [2:0] cmd;
        logic [7:0] b;
        int g;
        cmd = wr_command;
        cmd_vec = {cmd_vec[44:0], cmd};
        cmd_n++;
        if (cmd == 3'b011) begin
            b = 8'd0;
            for (int i = 0; i < 8; i++) begin
                b = {b[6:0], wr_data};
                wr_load = 1'b1;
                step();
                wr_load = 1'b0;
            end
            byte_vec = {byte_vec[55:0], b};
            byte_n++;
        end
        wr_finish = 1'b1;
        step();
        g = 0;
        while (wr_go === 1'b1 && g < 20) begin
            step();
            g++;
        end
        wr_finish = 1'b0;
        step();
    endtask

    task automatic serve_ack();
        ack_n++;
        ack_bit    = (ack_n == nack_at);
        ack_finish = 1'b1;
        step();
        ack_finish = 1'b0;
        ack_bit    = 1'b0;
    endtask

    task automatic serve_fetch();
        for (int i = 0; i < stall_cycles; i++) begin
            step();
            if (wr_go !== 1'b0 || tx_ready !== 1'b1) stall_bad++;
        end
        stall_cycles = 0;
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        if (tx_q.size() > 0) tx_data = tx_q.pop_front();
        step();
        tx_valid = 1'b0;
    endtask

    task automatic start_xfer(input logic [6:0] addr, input logic [3:0] cnt);
        cmd_vec = '0; cmd_n = 0; byte_vec = '0; byte_n = 0;
        done_cnt = 0; rdy_cnt = 0; ack_n = 0; stall_bad = 0;
        reset      = 1'b0;
        slave_addr = addr;
        byte_count = cnt;
        start_req  = 1'b1;
        step();
        start_req  = 1'b0;
    endtask

    task automatic run_xfer();
        int guard;
        guard = 0;
        while (busy === 1'b1 && guard < 3000) begin
            guard++;
            if (wr_go === 1'b1) serve_write();
            else if (ack_go === 1'b1) serve_ack();
            else if (tx_ready === 1'b1) serve_fetch();
            else step();
        end
        if (busy !== 1'b0) begin
            n_vec++; n_err++;
            $display("FAIL xfer_timeout busy=%b required 0", busy);
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; start_req = 1'b0; slave_addr = '0; byte_count = '0;
        tx_data = '0; tx_valid = 1'b0; wr_load = 1'b0; wr_finish = 1'b0;
        ack_finish = 1'b0; ack_bit = 1'b0; nack_at = 0; stall_cycles = 0;
        done_cnt = 0; rdy_cnt = 0;
        repeat (3) step();
        n_vec++;
        if ({busy, done, nack_err, wr_go, wr_command, wr_data, tx_ready, ack_go} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %b required 0000000000",
                     {busy, done, nack_err, wr_go, wr_command, wr_data, tx_ready, ack_go});
        end
        reset = 1'b0;
        step();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle busy=%b required 0", busy); end
    endtask

    task automatic test_basic();
        tx_q = '{8'hA5, 8'h3C};
        nack_at = 0;
        start_xfer(7'h50, 4'd2);
        n_vec++;
        if (busy !== 1'b1 || wr_go !== 1'b1 || wr_command !== 3'b001) begin
            n_err++;
            $display("FAIL basic_start busy=%b wr_go=%b cmd=%b required 1 1 001", busy, wr_go, wr_command);
        end
        run_xfer();
        n_vec++;
        if (cmd_n != 5 || cmd_vec !== 48'({3'b001, 3'b011, 3'b011, 3'b011, 3'b100})) begin
            n_err++; $display("FAIL basic_cmds n=%0d vec=%h required 5 cmds 001,011,011,011,100", cmd_n, cmd_vec);
        end
        n_vec++;
        if (byte_n != 3 || byte_vec !== 64'hA0A53C) begin
            n_err++; $display("FAIL basic_bytes n=%0d got %h required 3 bytes a0a53c", byte_n, byte_vec);
        end
        n_vec++;
        if (done_cnt != 1) begin n_err++; $display("FAIL basic_done pulses=%0d required 1", done_cnt); end
        n_vec++;
        if (nack_err !== 1'b0) begin n_err++; $display("FAIL basic_nack nack_err=%b required 0", nack_err); end
    endtask

    task automatic test_probe();
        tx_q = '{};
        nack_at = 0;
        start_xfer(7'h7F, 4'd0);
        run_xfer();
        n_vec++;
        if (cmd_n != 3 || cmd_vec !== 48'({3'b001, 3'b011, 3'b100})) begin
            n_err++; $display("FAIL probe_cmds n=%0d vec=%h required 3 cmds 001,011,100", cmd_n, cmd_vec);
        end
        n_vec++;
        if (byte_n != 1 || byte_vec !== 64'hFE) begin
            n_err++; $display("FAIL probe_addr n=%0d got %h required 1 byte fe", byte_n, byte_vec);
        end
        n_vec++;
        if (rdy_cnt != 0) begin n_err++; $display("FAIL probe_tx_ready cycles=%0d required 0", rdy_cnt); end
        n_vec++;
        if (done_cnt != 1) begin n_err++; $display("FAIL probe_done pulses=%0d required 1", done_cnt); end
    endtask

    task automatic test_nack();
        tx_q = '{8'h11, 8'h22, 8'h33};
        nack_at = 2;
        start_xfer(7'h2A, 4'd3);
        run_xfer();
        nack_at = 0;
`ifdef I2C_NACK_ABORT_EN
        n_vec++;
        if (cmd_n != 4 || cmd_vec !== 48'({3'b001, 3'b011, 3'b011, 3'b100})) begin
            n_err++; $display("FAIL nack_cmds n=%0d vec=%h required 4 cmds 001,011,011,100", cmd_n, cmd_vec);
        end
        n_vec++;
        if (byte_n != 2 || byte_vec !== 64'h5411) begin
            n_err++; $display("FAIL nack_bytes n=%0d got %h required 2 bytes 5411", byte_n, byte_vec);
        end
`else
        n_vec++;
        if (cmd_n != 6 || cmd_vec !== 48'({3'b001, 3'b011, 3'b011, 3'b011, 3'b011, 3'b100})) begin
            n_err++; $display("FAIL nack_cmds n=%0d vec=%h required 6 cmds 001,011x4,100", cmd_n, cmd_vec);
        end
        n_vec++;
        if (byte_n != 4 || byte_vec !== 64'h54112233) begin
            n_err++; $display("FAIL nack_bytes n=%0d got %h required 4 bytes 54112233", byte_n, byte_vec);
        end
`endif
        n_vec++;
        if (nack_err !== 1'b1) begin n_err++; $display("FAIL nack_sticky nack_err=%b required 1", nack_err); end
        n_vec++;
        if (done_cnt != 1) begin n_err++; $display("FAIL nack_done pulses=%0d required 1", done_cnt); end
    endtask

    task automatic test_stall();
        tx_q = '{8'hC3};
        nack_at = 0;
        start_xfer(7'h11, 4'd1);
        stall_cycles = 20;
        n_vec++;
        if (nack_err !== 1'b0) begin n_err++; $display("FAIL stall_nack_clear nack_err=%b required 0", nack_err); end
        run_xfer();
        n_vec++;
        if (stall_bad != 0) begin n_err++; $display("FAIL stall_hold bad_cycles=%0d required 0", stall_bad); end
        n_vec++;
        if (rdy_cnt != 21) begin n_err++; $display("FAIL stall_ready cycles=%0d required 21", rdy_cnt); end
        n_vec++;
        if (byte_n != 2 || byte_vec !== 64'h22C3) begin
            n_err++; $display("FAIL stall_bytes n=%0d got %h required 2 bytes 22c3", byte_n, byte_vec);
        end
    endtask

    task automatic test_busy_start();
        tx_q = '{8'h5A};
        nack_at = 0;
        start_xfer(7'h50, 4'd1);
        slave_addr = 7'h11;
        byte_count = 4'd5;
        start_req  = 1'b1;
        step();
        start_req  = 1'b0;
        run_xfer();
        n_vec++;
        if (cmd_n != 4 || cmd_vec !== 48'({3'b001, 3'b011, 3'b011, 3'b100})) begin
            n_err++; $display("FAIL busy_start_cmds n=%0d vec=%h required 4 cmds 001,011,011,100", cmd_n, cmd_vec);
        end
        n_vec++;
        if (byte_n != 2 || byte_vec !== 64'hA05A) begin
            n_err++; $display("FAIL busy_start_bytes n=%0d got %h required 2 bytes a05a", byte_n, byte_vec);
        end
        n_vec++;
        if (done_cnt != 1) begin n_err++; $display("FAIL busy_start_done pulses=%0d required 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        tx_q = '{8'hFF};
        nack_at = 0;
        start_xfer(7'h50, 4'd1);
        serve_write();
        serve_write();
        serve_ack();
        serve_fetch();
        n_vec++;
        if (wr_go !== 1'b1 || wr_command !== 3'b011) begin
            n_err++; $display("FAIL mid_data wr_go=%b cmd=%b required 1 011", wr_go, wr_command);
        end
        for (int i = 0; i < 3; i++) begin
            wr_load = 1'b1;
            step();
            wr_load = 1'b0;
        end
        n_vec++;
        if (wr_data !== 1'b1) begin n_err++; $display("FAIL mid_shift wr_data=%b required 1", wr_data); end
        reset = 1'b1;
        step();
        n_vec++;
        if ({busy, done, nack_err, wr_go, wr_command, wr_data, tx_ready, ack_go} !== 10'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs got %b required 0000000000",
                     {busy, done, nack_err, wr_go, wr_command, wr_data, tx_ready, ack_go});
        end
        tx_q = '{8'h96};
        start_xfer(7'h33, 4'd1);
        run_xfer();
        n_vec++;
        if (cmd_n != 4 || cmd_vec !== 48'({3'b001, 3'b011, 3'b011, 3'b100})) begin
            n_err++; $display("FAIL post_reset_cmds n=%0d vec=%h required 4 cmds 001,011,011,100", cmd_n, cmd_vec);
        end
        n_vec++;
        if (byte_n != 2 || byte_vec !== 64'h6696) begin
            n_err++; $display("FAIL post_reset_bytes n=%0d got %h required 2 bytes 6696", byte_n, byte_vec);
        end
        n_vec++;
        if (done_cnt != 1) begin n_err++; $display("FAIL post_reset_done pulses=%0d required 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_probe();
        test_nack();
        test_stall();
        test_busy_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
